key_io: RTL and testbench
=========================

KEY_IO -- requirements
Module: key_io

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 500000, stable-cycle count a key level must hold to be accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, held-cycle count flagging a long press (used only with KEY_IO_LONGPRESS_EN).
REQ-003 SHALL have port clk input 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst input 1, reset, synchronous and active-high.
REQ-005 SHALL have port key input 1, raw asynchronous key level, 1 = pressed.
REQ-006 SHALL have port io_rd input 1, CPU read strobe, one cycle per access.
REQ-007 SHALL have port io_wr input 1, CPU write strobe, one cycle per access.
REQ-008 SHALL have port io_addr input 1, register select: 0 = STATUS, 1 = COUNT.
REQ-009 SHALL have port io_din input 8, CPU write data.
REQ-010 SHALL have port io_dout output 8, registered read data.
REQ-011 SHALL have port key_evt output 1, one-cycle pulse per accepted press.

Function
REQ-012 SHALL pass key through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce with FSM IDLE -> PRESS_WAIT (sync key=1) -> PRESSED (stable DEBOUNCE cycles) -> RELEASE_WAIT (sync key=0) -> IDLE (stable DEBOUNCE cycles); any reversal during a WAIT state returns to the prior stable state and restarts the counter.
REQ-014 SHALL pulse key_evt for exactly one cycle on the PRESS_WAIT -> PRESSED transition.
REQ-015 SHALL increment 8-bit COUNT on each key_evt, wrapping 255 -> 0 and setting sticky STATUS bit1 (overflow) on wrap.
REQ-016 SHALL set sticky STATUS bit0 (pending) on each key_evt.
REQ-017 SHALL load io_dout one cycle after io_rd: {STATUS} for addr 0, COUNT for addr 1; io_dout holds its value when io_rd is low.
REQ-018 SHALL clear pending when COUNT is read, unless a key_evt occurs the same cycle (pending stays 1; io_dout returns pre-increment COUNT).
REQ-019 SHALL, on io_wr to addr 0 with io_din[0]=1, clear COUNT, pending and overflow; io_din[0]=0 and writes to addr 1 are ignored.
REQ-020 SHALL apply clear before increment when clear write and key_evt coincide: COUNT=1, pending=1, overflow=0.
REQ-021 SHALL treat io_rd and io_wr asserted together as a write only; io_dout unchanged.
REQ-022 SHALL read STATUS bits [7:3] as 0.

Reset
REQ-023 SHALL on rst force FSM to IDLE, debounce counter 0, synchronizer flops 0, COUNT 0, STATUS 0, io_dout 8'h00, key_evt 0.
REQ-024 SHALL, if rst asserts mid-debounce or while key is held, require a full fresh release-free press after reset (a key held through reset is counted once it has been stable DEBOUNCE cycles from IDLE).

Configuration
REQ-025 SHALL, with KEY_IO_LONGPRESS_EN defined, set sticky STATUS bit2 (long) when FSM stays in PRESSED for LONG_CYCLES, cleared by the REQ-019 clear write.
REQ-026 SHALL, without KEY_IO_LONGPRESS_EN, omit the long-press counter entirely and read STATUS bit2 as 0.

Structure
REQ-027 SHALL place register addresses, STATUS bit positions, data width 8 and FSM state encodings in shared package key_io_pkg.
REQ-028 SHALL implement synchronizer plus debounce FSM in sub-module key_debounce (outputs stable level and press pulse); key_io holds registers and bus logic.

Verification (DEBOUNCE=4, LONG_CYCLES=20)
REQ-029 SHALL cover: clean press held 10 cycles then released -> one key_evt, COUNT read = 8'h01, STATUS read = 8'h01 then 8'h00 after COUNT read.
REQ-030 SHALL cover: key toggling every 2 cycles for 20 cycles -> no key_evt, COUNT = 8'h00.
REQ-031 SHALL cover: 256 clean presses -> COUNT = 8'h00, STATUS = 8'h03; write addr 0 data 8'h01 -> STATUS = 8'h00.
REQ-032 SHALL cover: clear write in same cycle as key_evt with COUNT=5 -> COUNT = 8'h01, STATUS bit0 = 1.
REQ-033 SHALL cover: with KEY_IO_LONGPRESS_EN, hold 30 cycles -> STATUS = 8'h05; without it -> STATUS = 8'h01.
REQ-034 SHALL cover: rst pulsed during PRESS_WAIT -> all outputs 0 next cycle, no key_evt until key stable 4 cycles after release of rst.

Source files
------------

// File: rtl/key_io_pkg.sv
// Shared constants for the key_io block: register map, STATUS bit layout,
// bus data width and debounce FSM state encoding.
package key_io_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic ADDR_STATUS = 1'b0;
   localparam logic ADDR_COUNT  = 1'b1;

   localparam int unsigned ST_PEND = 0;
   localparam int unsigned ST_OVF  = 1;
   localparam int unsigned ST_LONG = 2;
   localparam int unsigned CLR_BIT = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } db_state_t;

   function automatic logic [DATA_W-1:0] pack_status(input logic pend,
                                                     input logic ovf,
                                                     input logic lng);
      logic [DATA_W-1:0] s;
      s          = '0;
      s[ST_PEND] = pend;
      s[ST_OVF]  = ovf;
      s[ST_LONG] = lng;
      return s;
   endfunction

endpackage

// File: rtl/key_io_if.sv
// CPU-side register bus of key_io: one-cycle read/write strobes,
// 1-bit register select and 8-bit data in each direction.
interface key_io_if;
   import key_io_pkg::*;

   logic              io_rd;
   logic              io_wr;
   logic              io_addr;
   logic [DATA_W-1:0] io_din;
   logic [DATA_W-1:0] io_dout;

   modport master (output io_rd, io_wr, io_addr, io_din, input io_dout);
   modport slave  (input io_rd, io_wr, io_addr, io_din, output io_dout);

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM; emits the accepted
// key level and a registered one-cycle pulse on each accepted press.
module key_debounce
   import key_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic level,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

   logic      s1, s2;
   db_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic      press_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= S_IDLE;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= key;
         s2    <= s1;
         state <= state_nx;
         cnt   <= cnt_nx;
         press <= press_nx;
      end
   end

   // Counter is zero whenever a WAIT state is entered or abandoned.
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      press_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (s2) state_nx = S_PRESS_WAIT;
         end
         S_PRESS_WAIT: begin
            if (!s2) begin
               state_nx = S_IDLE;
            end else if (cnt == LAST) begin
               state_nx = S_PRESSED;
               press_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_PRESSED: begin
            if (!s2) state_nx = S_RELEASE_WAIT;
         end
         S_RELEASE_WAIT: begin
            if (s2) begin
               state_nx = S_PRESSED;
            end else if (cnt == LAST) begin
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign level = (state == S_PRESSED) || (state == S_RELEASE_WAIT);

endmodule

// File: rtl/key_io.sv
// Debounced key with press counter and STATUS/COUNT CPU registers.
// Optional long-press flag (STATUS bit2) is built when KEY_IO_LONGPRESS_EN is defined.
module key_io
   import key_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE    = 500000,
   parameter int unsigned LONG_CYCLES = 50000000
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     key,
   key_io_if.slave  bus,
   output logic     key_evt
);

   logic              level;
   logic [DATA_W-1:0] count;
   logic              pend, ovf, lng;
   logic              clr, rd_ok;

   key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk   (clk),
      .rst   (rst),
      .key   (key),
      .level (level),
      .press (key_evt)
   );

   assign clr   = bus.io_wr && (bus.io_addr == ADDR_STATUS) && bus.io_din[CLR_BIT];
   assign rd_ok = bus.io_rd && !bus.io_wr;

   // A press coinciding with a clear lands on the freshly cleared counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         pend        <= 1'b0;
         ovf         <= 1'b0;
         bus.io_dout <= '0;
      end else begin
         if (rd_ok)
            bus.io_dout <= (bus.io_addr == ADDR_COUNT) ? count : pack_status(pend, ovf, lng);
         if (key_evt) begin
            count <= clr ? DATA_W'(1) : count + DATA_W'(1);
            pend  <= 1'b1;
            ovf   <= clr ? 1'b0 : (ovf | (count == '1));
         end else if (clr) begin
            count <= '0;
            pend  <= 1'b0;
            ovf   <= 1'b0;
         end else if (rd_ok && (bus.io_addr == ADDR_COUNT)) begin
            pend  <= 1'b0;
         end
      end
   end

`ifdef KEY_IO_LONGPRESS_EN
   localparam int unsigned LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
   localparam logic [LW-1:0] LL = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] lcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         lcnt <= '0;
         lng  <= 1'b0;
      end else begin
         if (!level)
            lcnt <= '0;
         else if (lcnt != LL)
            lcnt <= lcnt + LW'(1);
         if (clr)
            lng <= 1'b0;
         if (level && (lcnt == LL))
            lng <= 1'b1;
      end
   end
`else
   localparam int unsigned unused_long_cycles = LONG_CYCLES;
   logic unused_level;
   assign unused_level = level;
   assign lng          = 1'b0;
`endif

endmodule

// File: tb/tb_key_io.sv
// Self-checking bench for key_io (DEBOUNCE=4, LONG_CYCLES=20): run-length
// reference model checked every cycle, table vectors, directed corner cases.
module tb_key_io;

   localparam int D = 4;
   localparam int L = 20;

   logic clk = 1'b0;
   logic rst;
   logic key;
   logic key_evt;

   key_io_if bus ();

   key_io #(.DEBOUNCE(D), .LONG_CYCLES(L)) dut (
      .clk     (clk),
      .rst     (rst),
      .key     (key),
      .bus     (bus),
      .key_evt (key_evt)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_evt    = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the key level is accepted once the synchronised input
   // has disagreed with the accepted level for D+1 consecutive samples.
   logic m_s1, m_s2, m_acc, m_evt;
   int   m_run, m_lrun, m_count;
   logic m_pend, m_ovf, m_long;
   logic [7:0] m_dout;

   function automatic logic [7:0] m_status();
      return {5'b0, m_long, m_ovf, m_pend};
   endfunction

   always @(posedge clk) begin
      logic s, clr, rdo;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_acc = 0; m_evt = 0; m_run = 0; m_lrun = 0;
         m_count = 0; m_pend = 0; m_ovf = 0; m_long = 0; m_dout = 8'h00;
      end else begin
         clr = bus.io_wr && !bus.io_addr && bus.io_din[0];
         rdo = bus.io_rd && !bus.io_wr;
         if (rdo) m_dout = bus.io_addr ? 8'(m_count) : m_status();
         if (clr) begin m_count = 0; m_pend = 0; m_ovf = 0; m_long = 0; end
         if (rdo && bus.io_addr && !m_evt) m_pend = 0;
         if (m_evt) begin
            if (m_count == 255) m_ovf = 1;
            m_count = (m_count + 1) % 256;
            m_pend  = 1;
         end
         if (m_acc) m_lrun++; else m_lrun = 0;
`ifdef KEY_IO_LONGPRESS_EN
         if (m_lrun >= L) m_long = 1;
`endif
         s = m_s2; m_s2 = m_s1; m_s1 = key;
         m_evt = 0;
         if (s != m_acc) begin
            m_run++;
            if (m_run == D + 1) begin
               m_acc = s; m_run = 0; m_evt = s;
            end
         end else begin
            m_run = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_key_evt", key_evt, m_evt);
         check("model_io_dout", bus.io_dout, m_dout);
         if (key_evt === 1'b1) n_evt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd_reg(input logic a, output logic [7:0] d);
      bus.io_addr = a; bus.io_rd = 1'b1;
      @(negedge clk);
      bus.io_rd = 1'b0;
      d = bus.io_dout;
   endtask

   task automatic wr_reg(input logic a, input logic [7:0] d);
      bus.io_addr = a; bus.io_din = d; bus.io_wr = 1'b1;
      @(negedge clk);
      bus.io_wr = 1'b0; bus.io_din = 8'h00;
   endtask

   task automatic press(input int hold, input int rel);
      key = 1'b1; tick(hold);
      key = 1'b0; tick(rel);
   endtask

   typedef struct {
      int         presses;
      int         hold;
      logic [7:0] exp_count;
      logic [7:0] exp_status;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] d;
      int e0, wait_n, run;
      bit got;

      vecs[0] = '{1, 10, 8'h01, 8'h01};
      vecs[1] = '{3,  8, 8'h03, 8'h01};
      vecs[2] = '{2,  4, 8'h00, 8'h00};
      vecs[3] = '{1,  5, 8'h01, 8'h01};
      vecs[4] = '{0,  8, 8'h00, 8'h00};
`ifdef KEY_IO_LONGPRESS_EN
      vecs[5] = '{1, 30, 8'h01, 8'h05};
`else
      vecs[5] = '{1, 30, 8'h01, 8'h01};
`endif

      rst = 1'b1; key = 1'b0;
      bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = 1'b0; bus.io_din = 8'h00;
      tick(3);
      chk_en = 1'b1;
      check("reset_dout", bus.io_dout, 8'h00);
      check("reset_evt", key_evt, 1'b0);
      rst = 1'b0;
      tick(2);

      // Clean press, pending cleared by COUNT read
      e0 = n_evt;
      press(10, 10);
      check("clean_evt_count", n_evt - e0, 1);
      rd_reg(1'b0, d); check("clean_status", d, 8'h01);
      rd_reg(1'b1, d); check("clean_count", d, 8'h01);
      rd_reg(1'b0, d); check("clean_status_after", d, 8'h00);

      // Bouncing key never accepted
      wr_reg(1'b0, 8'h01);
      e0 = n_evt;
      for (int i = 0; i < 10; i++) begin
         key = ~key; tick(2);
      end
      key = 1'b0; tick(8);
      check("bounce_evt_count", n_evt - e0, 0);
      rd_reg(1'b1, d); check("bounce_count", d, 8'h00);

      // Table vectors
      for (int v = 0; v < 6; v++) begin
         wr_reg(1'b0, 8'h01);
         for (int p = 0; p < vecs[v].presses; p++) press(vecs[v].hold, 8);
         rd_reg(1'b0, d); check($sformatf("vec%0d_status", v), d, vecs[v].exp_status);
         rd_reg(1'b1, d); check($sformatf("vec%0d_count", v), d, vecs[v].exp_count);
      end

      // 256 presses wrap the counter and set overflow
      wr_reg(1'b0, 8'h01);
      for (int p = 0; p < 256; p++) press(6, 6);
      rd_reg(1'b0, d); check("wrap_status", d, 8'h03);
      rd_reg(1'b1, d); check("wrap_count", d, 8'h00);
      wr_reg(1'b1, 8'h01);
      rd_reg(1'b0, d); check("wrap_status_addr1_wr", d, 8'h02);
      wr_reg(1'b0, 8'h00);
      rd_reg(1'b0, d); check("wrap_status_din0_wr", d, 8'h02);
      wr_reg(1'b0, 8'h01);
      rd_reg(1'b0, d); check("wrap_status_cleared", d, 8'h00);

      // Clear write coinciding with key_evt
      for (int p = 0; p < 5; p++) press(8, 8);
      rd_reg(1'b1, d); check("coinc_pre_count", d, 8'h05);
      key = 1'b1; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (key_evt === 1'b1) got = 1'b1;
      end
      check("coinc_evt_seen", got, 1'b1);
      bus.io_addr = 1'b0; bus.io_din = 8'h01; bus.io_wr = 1'b1;
      @(negedge clk);
      bus.io_wr = 1'b0; bus.io_din = 8'h00;
      key = 1'b0; tick(8);
      rd_reg(1'b0, d); check("coinc_status", d, 8'h01);
      rd_reg(1'b1, d); check("coinc_count", d, 8'h01);

      // Read and write together behave as a write only
      bus.io_addr = 1'b0; bus.io_din = 8'h01; bus.io_rd = 1'b1; bus.io_wr = 1'b1;
      @(negedge clk);
      bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_din = 8'h00;
      check("rdwr_dout_hold", bus.io_dout, 8'h01);
      rd_reg(1'b1, d); check("rdwr_cleared", d, 8'h00);

      // Reset during PRESS_WAIT with key held through it
      press(8, 8);
      rd_reg(1'b1, d); check("rst_pre_count", d, 8'h01);
      key = 1'b1; tick(4);
      rst = 1'b1; tick(1);
      check("rst_mid_dout", bus.io_dout, 8'h00);
      check("rst_mid_evt", key_evt, 1'b0);
      rst = 1'b0;
      wait_n = 0; got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if (key_evt === 1'b1) begin got = 1'b1; wait_n = i; end
      end
      check("rst_evt_latency", wait_n, 7);
      key = 1'b0; tick(8);
      rd_reg(1'b1, d); check("rst_post_count", d, 8'h01);

      // Randomised traffic against the reference model
      run = 0;
      for (int c = 0; c < 4000; c++) begin
         int r;
         if (run == 0) begin
            key = ~key;
            run = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 12));
         end
         run--;
         r = $urandom_range(0, 15);
         bus.io_addr = 1'($urandom_range(0, 1));
         bus.io_din  = 8'($urandom_range(0, 255));
         bus.io_rd   = (r <= 2) || (r == 4);
         bus.io_wr   = (r == 3) || (r == 4);
         rst         = ($urandom_range(0, 599) == 0);
         @(negedge clk);
      end
      bus.io_rd = 1'b0; bus.io_wr = 1'b0; rst = 1'b0; key = 1'b0;
      tick(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
